adc_capture_mc: RTL and testbench

Multi-channel successor to the single-channel ADC capture block. It captures NUM_CH parallel ADC samples per `adc_valid` beat and optionally converts each from offset-binary to two's complement. Captured frames are buffered in a frame FIFO, then serialised onto a 32-bit valid/ready stream, one channel per beat. It sits between the ADC pins (`clk_adc` domain) and the DDC/decimation chain, and also provides per-channel overflow counting and drop accounting.

---
 rtl/adc_capture_mc.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_adc_capture_mc.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_mc.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_mc
// Purpose  : Multi-channel ADC frame capture. Each adc_valid beat captures
//            NUM_CH samples, optionally converting them from offset binary
//            to two's complement. Frames are buffered in a frame FIFO and
//            serialised onto a 32-bit valid/ready stream, one channel per
//            beat. The block also keeps per-channel overflow counters,
//            sticky flags and a saturating count of dropped frames.
// Ports    : clk_adc         - sole clock, rising edge
//            rst             - asynchronous active-high reset
//            adc_data        - NUM_CH packed samples, ch c at [c*W +: W]
//            adc_valid       - frame strobe
//            adc_ovr         - per-channel over-range, qualified by adc_valid
//            fmt_twos        - 1: two's complement, 0: offset-binary passthru
//            ovr_clear       - clears overflow counters and sticky flags
//            out_data        - sign/zero extended sample
//            out_chan        - channel index of out_data
//            out_ovr         - over-range bit captured with this sample
//            out_last        - high on the last channel of a frame
//            out_valid       - stream valid
//            out_ready       - stream ready
//            overflow_detect - any channel counter at or above OVR_THRESH
//            ovr_sticky      - per-channel sticky overflow
//            drop_count      - saturating count of frames dropped on full
//            fifo_full       - FIFO holds FIFO_DEPTH frames
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture_mc #(
  parameter int ADC_WIDTH  = 10,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int OVR_THRESH = 3,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk_adc,
  input  logic                        rst,
  input  logic [NUM_CH*ADC_WIDTH-1:0] adc_data,
  input  logic                        adc_valid,
  input  logic [NUM_CH-1:0]           adc_ovr,
  input  logic                        fmt_twos,
  input  logic                        ovr_clear,
  output logic [31:0]                 out_data,
  output logic [CH_W-1:0]             out_chan,
  output logic                        out_ovr,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overflow_detect,
  output logic [NUM_CH-1:0]           ovr_sticky,
  output logic [15:0]                 drop_count,
  output logic                        fifo_full
);

  localparam int              AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              FW        = NUM_CH * ADC_WIDTH;
  localparam logic [AW:0]     C_DEPTH   = (AW+1)'(FIFO_DEPTH);
  localparam logic [CH_W-1:0] C_LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [7:0]      C_THRESH  = 8'(OVR_THRESH);
  localparam logic [ADC_WIDTH-1:0] C_MSB = ADC_WIDTH'(1) << (ADC_WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Capture-side conversion: inverting the MSB of an offset-binary code gives
  // the two's complement code of the same value.
  // --------------------------------------------------------------------------
  logic [FW-1:0] w_conv;
  logic [ADC_WIDTH-1:0] w_msb_flip;

  assign w_msb_flip = {ADC_WIDTH{fmt_twos}} & C_MSB;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_conv
      assign w_conv[g*ADC_WIDTH +: ADC_WIDTH] =
        adc_data[g*ADC_WIDTH +: ADC_WIDTH] ^ w_msb_flip;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Frame FIFO
  // --------------------------------------------------------------------------
  logic [FW-1:0]     r_mem_data [FIFO_DEPTH];
  logic [NUM_CH-1:0] r_mem_ovr  [FIFO_DEPTH];
  logic              r_mem_fmt  [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [AW:0]       w_count_nxt;
  logic              r_full;
  logic              w_empty;
  logic              w_full_now;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;

  assign w_empty    = (r_count == '0);
  assign w_full_now = (r_count == C_DEPTH);
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_push     = adc_valid & (~w_full_now | w_pop);
  assign w_drop     = adc_valid & w_full_now & ~w_pop;
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge clk_adc) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_conv;
      r_mem_ovr[r_wr_ptr]  <= adc_ovr;
      r_mem_fmt[r_wr_ptr]  <= fmt_twos;
    end
  end

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_DEPTH);
    end
  end

  assign fifo_full = r_full;

  // --------------------------------------------------------------------------
  // Serialiser FSM
  // --------------------------------------------------------------------------
  state_t          r_state;
  state_t          w_state_nxt;
  logic [CH_W-1:0] r_chan;
  logic [CH_W-1:0] w_chan_nxt;
  logic [FW-1:0]   r_frm_data;
  logic [NUM_CH-1:0] r_frm_ovr;
  logic            r_frm_fmt;

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_chan  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_chan  <= w_chan_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_chan_nxt  = r_chan;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_chan_nxt  = '0;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (r_chan != C_LAST_CH) begin
            w_chan_nxt = r_chan + 1'b1;
          end else if (!w_empty) begin
            // Back-to-back frame: reload without an idle bubble.
            w_pop      = 1'b1;
            w_chan_nxt = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      r_frm_data <= '0;
      r_frm_ovr  <= '0;
      r_frm_fmt  <= 1'b0;
    end else if (w_pop) begin
      r_frm_data <= r_mem_data[r_rd_ptr];
      r_frm_ovr  <= r_mem_ovr[r_rd_ptr];
      r_frm_fmt  <= r_mem_fmt[r_rd_ptr];
    end
  end

  // Channel select as an explicit mux so non-power-of-two NUM_CH never
  // indexes past the frame.
  logic [ADC_WIDTH-1:0] w_smp;
  logic                 w_smp_ovr;

  always_comb begin
    w_smp     = '0;
    w_smp_ovr = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_chan == CH_W'(c)) begin
        w_smp     = r_frm_data[c*ADC_WIDTH +: ADC_WIDTH];
        w_smp_ovr = r_frm_ovr[c];
      end
    end
  end

  always_comb begin
    if (r_frm_fmt) begin
      out_data = {{(32-ADC_WIDTH){w_smp[ADC_WIDTH-1]}}, w_smp};
    end else begin
      out_data = {{(32-ADC_WIDTH){1'b0}}, w_smp};
    end
  end

  assign out_valid = (r_state == S_EMIT);
  assign out_chan  = r_chan;
  assign out_ovr   = w_smp_ovr;
  // Gated with valid so a single-channel build still reads 0 in reset/idle.
  assign out_last  = out_valid & (r_chan == C_LAST_CH);

  // --------------------------------------------------------------------------
  // Overflow accounting
  // --------------------------------------------------------------------------
  logic [7:0]        r_ovr_cnt     [NUM_CH];
  logic [7:0]        w_ovr_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] r_ovr_sticky;
  logic [NUM_CH-1:0] w_sticky_nxt;
  logic              r_ovr_detect;
  logic              w_detect_nxt;

  always_comb begin
    w_sticky_nxt = r_ovr_sticky;
    w_detect_nxt = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_ovr_cnt_nxt[c] = r_ovr_cnt[c];
      // Clear takes priority over an overflow on the same edge.
      if (ovr_clear) begin
        w_ovr_cnt_nxt[c] = 8'd0;
        w_sticky_nxt[c]  = 1'b0;
      end else if (adc_valid && adc_ovr[c]) begin
        if (r_ovr_cnt[c] != 8'hFF) w_ovr_cnt_nxt[c] = r_ovr_cnt[c] + 8'd1;
        w_sticky_nxt[c] = 1'b1;
      end
      if (w_ovr_cnt_nxt[c] >= C_THRESH) w_detect_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) r_ovr_cnt[c] <= 8'd0;
      r_ovr_sticky <= '0;
      r_ovr_detect <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) r_ovr_cnt[c] <= w_ovr_cnt_nxt[c];
      r_ovr_sticky <= w_sticky_nxt;
      r_ovr_detect <= w_detect_nxt;
    end
  end

  assign ovr_sticky      = r_ovr_sticky;
  assign overflow_detect = r_ovr_detect;

  // --------------------------------------------------------------------------
  // Drop accounting (not affected by ovr_clear)
  // --------------------------------------------------------------------------
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= 16'd0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_count = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_mc
// Purpose  : Self-checking bench for adc_capture_mc. A queue-based model of
//            the frame buffer and serialiser predicts every output; directed
//            frames with hand-computed values pin the model, then randomised
//            traffic exercises fill, drop, backpressure and reset.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adc_capture_mc;

  localparam int W     = 10;
  localparam int NCH   = 2;
  localparam int DEPTH = 8;
  localparam int THR   = 3;
  localparam int CHW   = 1;

  logic             clk_adc = 1'b0;
  logic             rst = 1'b1;
  logic [NCH*W-1:0] adc_data = '0;
  logic             adc_valid = 1'b0;
  logic [NCH-1:0]   adc_ovr = '0;
  logic             fmt_twos = 1'b1;
  logic             ovr_clear = 1'b0;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [CHW-1:0]   out_chan;
  logic             out_ovr;
  logic             out_last;
  logic             out_valid;
  logic             overflow_detect;
  logic [NCH-1:0]   ovr_sticky;
  logic [15:0]      drop_count;
  logic             fifo_full;

  always #5 clk_adc = ~clk_adc;

  adc_capture_mc #(
    .ADC_WIDTH (W),
    .NUM_CH    (NCH),
    .FIFO_DEPTH(DEPTH),
    .OVR_THRESH(THR),
    .CH_W      (CHW)
  ) dut (
    .clk_adc        (clk_adc),
    .rst            (rst),
    .adc_data       (adc_data),
    .adc_valid      (adc_valid),
    .adc_ovr        (adc_ovr),
    .fmt_twos       (fmt_twos),
    .ovr_clear      (ovr_clear),
    .out_data       (out_data),
    .out_chan       (out_chan),
    .out_ovr        (out_ovr),
    .out_last       (out_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .overflow_detect(overflow_detect),
    .ovr_sticky     (ovr_sticky),
    .drop_count     (drop_count),
    .fifo_full      (fifo_full)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: queue of converted frames plus the frame in service.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [NCH-1:0][31:0] w;
    logic [NCH-1:0]       ovr;
  } frame_t;

  frame_t         m_fifo[$];
  frame_t         m_cur = '0;
  int             m_idx = 0;
  bit             m_busy = 1'b0;
  int             m_cnt[NCH];
  logic [NCH-1:0] m_sticky = '0;
  int             m_drop = 0;

  always @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      m_fifo.delete();
      m_cur    = '0;
      m_idx    = 0;
      m_busy   = 1'b0;
      m_sticky = '0;
      m_drop   = 0;
      foreach (m_cnt[c]) m_cnt[c] = 0;
    end else begin : b_upd
      frame_t       nf;
      frame_t       f;
      bit           pop;
      logic [W-1:0] raw;
      f  = '0;
      nf = '0;
      for (int c = 0; c < NCH; c++) begin
        raw = adc_data[c*W +: W];
        // Offset binary to signed: subtract half scale.
        nf.w[c] = fmt_twos ? 32'(int'(raw) - 2**(W-1)) : 32'(raw);
      end
      nf.ovr = adc_ovr;
      pop = (m_fifo.size() > 0) && (!m_busy || (m_idx == NCH-1 && out_ready));
      if (pop) f = m_fifo.pop_front();
      if (adc_valid) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(nf);
        else if (m_drop < 65535) m_drop++;
      end
      if (!m_busy) begin
        if (pop) begin m_cur = f; m_idx = 0; m_busy = 1'b1; end
      end else if (out_ready) begin
        if (m_idx < NCH-1) m_idx++;
        else if (pop) begin m_cur = f; m_idx = 0; end
        else m_busy = 1'b0;
      end
      for (int c = 0; c < NCH; c++) begin
        if (ovr_clear) begin
          m_cnt[c] = 0; m_sticky[c] = 1'b0;
        end else if (adc_valid && adc_ovr[c]) begin
          if (m_cnt[c] < 255) m_cnt[c]++;
          m_sticky[c] = 1'b1;
        end
      end
    end
  end

  // Compare process: every negedge, outputs against the model.
  always @(negedge clk_adc) begin : b_cmp
    bit det;
    det = 1'b0;
    foreach (m_cnt[c]) if (m_cnt[c] >= THR) det = 1'b1;
    chk("model out_valid", 32'(out_valid), 32'(m_busy));
    if (m_busy) begin
      chk("model out_data", out_data, m_cur.w[m_idx]);
      chk("model out_chan", 32'(out_chan), 32'(m_idx));
      chk("model out_ovr", 32'(out_ovr), 32'(m_cur.ovr[m_idx]));
      chk("model out_last", 32'(out_last), 32'(m_idx == NCH-1));
    end else begin
      chk("model out_last idle", 32'(out_last), 32'd0);
    end
    chk("model ovr_sticky", 32'(ovr_sticky), 32'(m_sticky));
    chk("model overflow_detect", 32'(overflow_detect), 32'(det));
    chk("model drop_count", 32'(drop_count), 32'(m_drop));
    chk("model fifo_full", 32'(fifo_full), 32'(m_fifo.size() == DEPTH));
  end

  // --------------------------------------------------------------------------
  // Stimulus. Inputs change 2 ns after the rising edge; literal checks sit on
  // the falling edge (3 ns later).
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_adc);
    #2;
  endtask

  task automatic frame(input logic [W-1:0] c0, input logic [W-1:0] c1,
                       input logic [NCH-1:0] ovr);
    adc_data  = {c1, c0};
    adc_ovr   = ovr;
    adc_valid = 1'b1;
  endtask

  int vp[4] = '{50, 95, 30, 90};
  int rp[4] = '{100, 40, 70, 20};
  int cp[4] = '{40, 40, 40, 0};

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    #3;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_chan", 32'(out_chan), 32'd0);
    chk("reset out_last", 32'(out_last), 32'd0);
    chk("reset out_ovr", 32'(out_ovr), 32'd0);
    chk("reset drop_count", 32'(drop_count), 32'd0);
    chk("reset fifo_full", 32'(fifo_full), 32'd0);
    chk("reset ovr_sticky", 32'(ovr_sticky), 32'd0);
    chk("reset overflow_detect", 32'(overflow_detect), 32'd0);

    // Two's complement frames
    tick();
    frame(10'h1FF, 10'h200, 2'b00);
    tick();
    adc_valid = 1'b0;
    tick(); #3;
    chk("twos f1 ch0 valid", 32'(out_valid), 32'd1);
    chk("twos f1 ch0 data", out_data, 32'hFFFF_FFFF);
    chk("twos f1 ch0 chan", 32'(out_chan), 32'd0);
    chk("twos f1 ch0 last", 32'(out_last), 32'd0);
    tick(); #3;
    chk("twos f1 ch1 data", out_data, 32'h0000_0000);
    chk("twos f1 ch1 chan", 32'(out_chan), 32'd1);
    chk("twos f1 ch1 last", 32'(out_last), 32'd1);
    tick();
    frame(10'h000, 10'h100, 2'b00);
    tick();
    adc_valid = 1'b0;
    tick(); #3;
    chk("twos f2 ch0 data", out_data, 32'hFFFF_FE00);
    tick(); #3;
    chk("twos f2 ch1 data", out_data, 32'hFFFF_FF00);

    // Offset binary, format toggled while the frame is queued
    tick();
    fmt_twos = 1'b0;
    frame(10'h200, 10'h3FF, 2'b00);
    tick();
    adc_valid = 1'b0;
    fmt_twos  = 1'b1;
    tick(); #3;
    chk("offset ch0 data", out_data, 32'h0000_0200);
    tick(); #3;
    chk("offset ch1 data", out_data, 32'h0000_03FF);

    // Overflow threshold and clear
    tick();
    frame(10'h001, 10'h002, 2'b01);
    tick();
    tick(); #3;
    chk("ovr after 2 detect", 32'(overflow_detect), 32'd0);
    chk("ovr after 2 sticky", 32'(ovr_sticky), 32'b01);
    tick();
    adc_valid = 1'b0;
    adc_ovr   = '0;
    #3;
    chk("ovr after 3 detect", 32'(overflow_detect), 32'd1);
    chk("ovr after 3 sticky", 32'(ovr_sticky), 32'b01);
    tick();
    ovr_clear = 1'b1;
    tick();
    ovr_clear = 1'b0;
    #3;
    chk("ovr clear detect", 32'(overflow_detect), 32'd0);
    chk("ovr clear sticky", 32'(ovr_sticky), 32'd0);
    repeat (8) tick();

    // Backpressure: 10 frames, 9 retained, 1 dropped
    fmt_twos  = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      frame(W'(i), W'(32'h100 + i), 2'b00);
      tick();
    end
    adc_valid = 1'b0;
    #3;
    chk("bp fifo_full", 32'(fifo_full), 32'd1);
    chk("bp drop_count", 32'(drop_count), 32'd1);
    chk("bp head data", out_data, 32'd1);
    // Full FIFO, pop and push on the same last-channel handshake
    tick();
    out_ready = 1'b1;
    tick();
    frame(W'(11), W'(32'h10B), 2'b00);
    tick();
    adc_valid = 1'b0;
    #3;
    chk("simul pop fifo_full", 32'(fifo_full), 32'd1);
    chk("simul pop drop_count", 32'(drop_count), 32'd1);
    chk("simul pop next data", out_data, 32'd2);
    repeat (24) tick();
    #3;
    chk("drained fifo_full", 32'(fifo_full), 32'd0);
    chk("drained out_valid", 32'(out_valid), 32'd0);

    // Reset mid-frame
    tick();
    out_ready = 1'b0;
    frame(10'h005, 10'h006, 2'b00);
    tick();
    frame(10'h007, 10'h008, 2'b00);
    tick();
    adc_valid = 1'b0;
    #3;
    chk("pre-reset out_valid", 32'(out_valid), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    #3;
    chk("post-reset out_valid", 32'(out_valid), 32'd0);

    // Randomised traffic in four load/backpressure regimes
    for (int seg = 0; seg < 4; seg++) begin
      for (int k = 0; k < 1000; k++) begin
        adc_valid = ($urandom_range(99) < vp[seg]);
        adc_data  = (NCH*W)'($urandom);
        adc_ovr   = (seg == 3) ? (($urandom_range(9) < 8) ? 2'b11 : 2'b00)
                               : NCH'($urandom);
        fmt_twos  = 1'($urandom);
        ovr_clear = ($urandom_range(999) < cp[seg]);
        out_ready = ($urandom_range(99) < rp[seg]);
        rst       = (seg == 2 && k == 500);
        tick();
      end
    end
    rst       = 1'b0;
    adc_valid = 1'b0;
    ovr_clear = 1'b0;
    out_ready = 1'b1;
    repeat (30) tick();
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
